// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/add/sub/slt/nor in 1 cycle, shift-add mul and restoring divide in WIDTH+1.
// Valid/ready on both sides; a result held in DONE under back-pressure blocks new requests.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic [1:0]         op;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     msum, rsh, diff;
  logic               accept, long_op;

  // 10xx selects the iterative multiply/divide family
  assign long_op = (control[3:2] == 2'b10);
  assign accept  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = long_op ? BUSY : DONE;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = long_op ? BUSY : DONE;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = in1;
    case (control)
      4'b0000: alu_res = in0 & in1;
      4'b0001: alu_res = in0 | in1;
      4'b0010: alu_res = in0 + in1;
      4'b0110: alu_res = in0 - in1;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      4'b1100: alu_res = ~(in0 | in1);
      default: alu_res = in1;
    endcase
  end

  // acc holds {partial product high, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rsh  = acc[2*WIDTH-1:WIDTH-1];
    diff = rsh - {1'b0, opb};
    if (!op[1])
      acc_nxt = {msum, acc[WIDTH-1:1]};
    else if (diff[WIDTH])
      acc_nxt = {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      acc  <= '0;
      opb  <= '0;
      op   <= '0;
      out  <= '0;
      zero <= 1'b0;
    end else if (accept) begin
      op   <= control[1:0];
      opb  <= in1;
      acc  <= {{WIDTH{1'b0}}, in0};
      zero <= (in0 == in1);
      if (long_op) cnt <= CW'(WIDTH - 1);
      else         out <= alu_res;
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      if (cnt == '0)
        // op[0] picks the high half: mulhu and remu
        out <= op[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
      else
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: table of vectors through a result scoreboard, plus reset/latency/handshake sequences.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [W-1:0] in0, in1, out;
  logic [3:0]   control;

  logic         iv8, ir8, ov8, or8, z8, bz8;
  logic [7:0]   a8, b8, o8;
  logic [3:0]   c8;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic         z;
  } vec_t;
  vec_t tv[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .control(control), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .busy(busy)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in0(a8), .in1(b8), .control(c8), .out_valid(ov8),
    .out_ready(or8), .out(o8), .zero(z8), .busy(bz8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: a result retires on the edge following a negedge with out_valid & out_ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(out_valid), 64'(0));
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result_out", 64'(out), 64'(e[W-1:0]));
        check("result_zero", 64'(zero), 64'(e[W]));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge with in_valid still high
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] e, input logic z, output int waits);
    exp_q.push_back({z, e});
    in_valid = 1'b1;
    control  = c;
    in0      = a;
    in1      = b;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 200);
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check({tag, "_out"}, 64'(out), 64'(0));
    check({tag, "_zero"}, 64'(zero), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e, input string name);
    int n = 0;
    c8  = c;
    a8  = a;
    b8  = b;
    iv8 = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 64'(ir8), 64'(1));
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov8 && n < 50);
    check({name, "_latency"}, 64'(n), 64'(9));
    check({name, "_out"}, 64'(o8), 64'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, n, ir_bad, busy_cnt, ov_seen;

    tv.push_back('{4'b0000, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h00F0_0000, 1'b0});
    tv.push_back('{4'b0001, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0});
    tv.push_back('{4'b1100, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0});
    tv.push_back('{4'b0110, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hE0FF_0001, 1'b0});
    tv.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    tv.push_back('{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    tv.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0});
    tv.push_back('{4'b0101, 32'h0000_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
    tv.push_back('{4'b1111, 32'h0000_0005, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0});
    tv.push_back('{4'b0010, 32'h0000_1234, 32'h0000_1234, 32'h0000_2468, 1'b1});
    tv.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0});
    tv.push_back('{4'b1001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0});
    tv.push_back('{4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1});
    tv.push_back('{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
    tv.push_back('{4'b1010, 32'd100,       32'd7,         32'd14,        1'b0});
    tv.push_back('{4'b1011, 32'd100,       32'd7,         32'd2,         1'b0});
    tv.push_back('{4'b1010, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0});
    tv.push_back('{4'b1011, 32'd5,         32'd0,         32'd5,         1'b0});
    tv.push_back('{4'b1010, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 1'b0});
    tv.push_back('{4'b1011, 32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in0       = '0;
    in1       = '0;
    control   = '0;
    iv8       = 1'b0;
    or8       = 1'b1;
    a8        = '0;
    b8        = '0;
    c8        = '0;
    #12;
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++)
      issue(tv[i].c, tv[i].a, tv[i].b, tv[i].e, tv[i].z, w);
    in_valid = 1'b0;
    drain();

    do_reset("rst_idle");

    // Reset while iterating, counter at WIDTH/2
    issue(4'b1000, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, w);
    in_valid = 1'b0;
    repeat (W/2 - 1) @(posedge clk);
    #2;
    check("busy_before_rst", 64'(busy), 64'(1));
    do_reset("rst_busy");
    ov_seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("aborted_no_result", 64'(ov_seen), 64'(0));
    @(posedge clk);
    #1;

    // Multiply latency and in_ready low throughout BUSY
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, w);
    in_valid = 1'b0;
    n = 0; ir_bad = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) begin
        if (in_ready) ir_bad++;
        if (busy) busy_cnt++;
      end
    end while (!out_valid && n < 100);
    check("mul_latency", 64'(n), 64'(W + 1));
    check("mul_in_ready_low", 64'(ir_bad), 64'(0));
    check("mul_busy_cycles", 64'(busy_cnt), 64'(W));
    @(posedge clk);
    #1;

    // Operand changes during BUSY must not disturb the divide
    issue(4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, w);
    in_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      in0     = $urandom;
      in1     = $urandom;
      control = 4'($urandom);
    end
    drain();

    // Back-pressure: result held for 5 cycles with a request pending
    out_ready = 1'b0;
    issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, w);
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_003C});
    in_valid = 1'b1;
    control  = 4'b0001;
    in0      = 32'h30;
    in1      = 32'h0C;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out", 64'(out), 64'(7));
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Back-to-back adds: one accept per cycle
    issue(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, w);
    for (int i = 0; i < 6; i++) begin
      issue(4'b0010, 32'(i * 1000), 32'(i + 5), 32'(i * 1000 + i + 5), 1'b0, w);
      check("b2b_accept_wait", 64'(w), 64'(1));
    end
    in_valid = 1'b0;
    drain();

    // Reset in DONE with the result held
    out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b1, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("done_hold_out", 64'(out), 64'(2));
    check("done_hold_zero", 64'(zero), 64'(1));
    @(posedge clk);
    #2;
    do_reset("rst_done");
    out_ready = 1'b1;
    issue(4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, w);
    in_valid = 1'b0;
    drain();

    run8(4'b1000, 8'hFF, 8'h02, 8'hFE, "w8_mul");
    run8(4'b1001, 8'hFF, 8'h02, 8'h01, "w8_mulhu");
    run8(4'b1010, 8'd100, 8'd7, 8'd14, "w8_divu");
    run8(4'b1011, 8'd100, 8'd7, 8'd2, "w8_remu");
    run8(4'b1010, 8'd5, 8'd0, 8'hFF, "w8_divu0");
    run8(4'b1011, 8'd5, 8'd0, 8'd5, "w8_remu0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
